alupl_commit_queue: RTL and testbench

// - Commit-side stage directly downstream of the ALU pipeline WB stage.
// - Accepts completed ALU results (pl_out_t) through a valid/ready handshake and buffers them in order.
// - Requests the shared register-file write port and writes results.
// - Releases scoreboard reservations and reports retirement.
// - Holds at any error entry until the pipeline is flushed.

---
 rtl/super_pkg.sv | 39 +++
 rtl/alupl_commit_queue_cq_fifo.sv | 59 +++++
 rtl/alupl_commit_queue.sv | 127 ++++++++++++
 tb/tb_alupl_commit_queue.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/super_pkg.sv
// Shared types for the ALU pipeline and its commit stage.
// Holds result bundles, WAW broadcast and queue state.
package super_pkg;

  localparam int OpW           = 65;
  localparam int AluCqDepthDef = 2;

  typedef struct packed {
    logic            we;
    logic            wrsv;
    logic [4:0]      waddr;
    logic [OpW-1:0]  wdata;
    logic            err;
    logic [31:0]     pc;
    logic [5:0]      mcause;
    logic [31:0]     mtval;
  } pl_out_t;

  typedef struct packed {
    logic [1:0] valid;
    logic [4:0] rd0;
    logic [4:0] rd1;
  } waw_act_t;

  typedef enum logic {
    CQ_RUN,
    CQ_HOLD
  } alupl_cq_state_e;

  // A younger writer to the same rd owns the reservation now.
  function automatic logic waw_hit(
    input waw_act_t   w,
    input logic [4:0] a
  );
    return (w.valid[0] && (w.rd0 == a)) ||
           (w.valid[1] && (w.rd1 == a));
  endfunction

endpackage

// File: rtl/alupl_commit_queue_cq_fifo.sv
// In-order result storage for the ALU commit queue.
// Pointers wrap modulo Depth; wrsv bits clear per entry.
module cq_fifo
  import super_pkg::*;
#(
  parameter  int Depth = AluCqDepthDef,
  localparam int AW    = $clog2(Depth),
  localparam int CW    = AW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  pl_out_t               push_data_i,
  input  logic                  pop_i,
  input  logic [Depth-1:0]      clr_i,
  output pl_out_t               head_o,
  output pl_out_t [Depth-1:0]   ent_o,
  output logic [CW-1:0]         count_o
);

  pl_out_t [Depth-1:0] r_mem;
  logic [AW-1:0]       r_rd;
  logic [AW-1:0]       r_wr;
  logic [CW-1:0]       r_cnt;

  assign head_o  = r_mem[r_rd];
  assign ent_o   = r_mem;
  assign count_o = r_cnt;

  // Storage, pointers and occupancy; flush empties the queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (clr_i[i]) r_mem[i].wrsv <= 1'b0;
      end
      if (push_i) begin
        r_mem[r_wr] <= push_data_i;
        r_wr        <= r_wr + 1'b1;
      end
      if (pop_i) r_rd <= r_rd + 1'b1;
      case ({push_i, pop_i})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/alupl_commit_queue.sv
// Commit stage behind the ALU pipeline WB stage.
// Writes results in order, releases reservations, holds on error.
module alupl_commit_queue
  import super_pkg::*;
#(
  parameter int   Depth     = AluCqDepthDef,
  parameter logic CHERIoTEn = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           alupl_valid_i,
  input  pl_out_t        alupl_output_i,
  output logic           alupl_ds_rdy_o,
  input  waw_act_t       waw_act_i,
  output logic           rf_wreq_o,
  input  logic           rf_wgnt_i,
  output logic           rf_we_o,
  output logic [4:0]     rf_waddr_o,
  output logic [OpW-1:0] rf_wdata_o,
  output logic           rf_wrsv_clr_o,
  output logic           retire_valid_o,
  output logic [31:0]    retire_pc_o,
  output logic           exc_valid_o,
  output logic [31:0]    exc_pc_o,
  output logic [5:0]     exc_mcause_o,
  output logic [31:0]    exc_mtval_o
);

  localparam int CW = $clog2(Depth) + 1;

  alupl_cq_state_e     r_state;
  alupl_cq_state_e     w_nxt;
  pl_out_t             w_head;
  pl_out_t [Depth-1:0] w_ent;
  pl_out_t             w_push_data;
  logic [CW-1:0]       w_cnt;
  logic [Depth-1:0]    w_clr;
  logic [OpW-1:0]      w_wdata;
  logic                w_push;
  logic                w_pop;
  logic                w_hvld;
  logic                w_ready;

  assign w_hvld  = (w_cnt != '0);
  assign w_ready = (w_cnt != CW'(Depth)) &&
                   (r_state == CQ_RUN);
  assign alupl_ds_rdy_o = w_ready && !rst_i;
  assign w_push  = alupl_valid_i && w_ready && !flush_i;

  // WAW compare on stored entries and on the incoming entry.
  always_comb begin
    w_clr       = '0;
    w_push_data = alupl_output_i;
    for (int i = 0; i < Depth; i++) begin
      w_clr[i] = waw_hit(waw_act_i, w_ent[i].waddr);
    end
    if (waw_hit(waw_act_i, alupl_output_i.waddr)) begin
      w_push_data.wrsv = 1'b0;
    end
  end

  // Capability upper bits are dropped on non-CHERIoT builds.
  always_comb begin
    w_wdata = w_head.wdata;
    if (!CHERIoTEn) w_wdata[OpW-1:32] = '0;
  end

  // Head decode: error hold, silent retire or RF write.
  always_comb begin
    w_nxt          = r_state;
    w_pop          = 1'b0;
    rf_wreq_o      = 1'b0;
    rf_we_o        = 1'b0;
    rf_wrsv_clr_o  = 1'b0;
    retire_valid_o = 1'b0;
    if (flush_i) begin
      w_nxt = CQ_RUN;
    end else if ((r_state == CQ_RUN) && w_hvld) begin
      if (w_head.err) begin
        w_nxt = CQ_HOLD;
      end else if (!w_head.we || (w_head.waddr == 5'd0)) begin
        w_pop          = 1'b1;
        retire_valid_o = 1'b1;
      end else begin
        rf_wreq_o = 1'b1;
        if (rf_wgnt_i) begin
          w_pop          = 1'b1;
          rf_we_o        = 1'b1;
          retire_valid_o = 1'b1;
          rf_wrsv_clr_o  = w_head.wrsv &&
                           !waw_hit(waw_act_i, w_head.waddr);
        end
      end
    end
  end

  assign rf_waddr_o   = rf_wreq_o ? w_head.waddr : '0;
  assign rf_wdata_o   = rf_wreq_o ? w_wdata : '0;
  assign retire_pc_o  = retire_valid_o ? w_head.pc : '0;
  assign exc_valid_o  = (r_state == CQ_HOLD) && !flush_i;
  assign exc_pc_o     = exc_valid_o ? w_head.pc : '0;
  assign exc_mcause_o = exc_valid_o ? w_head.mcause : '0;
  assign exc_mtval_o  = exc_valid_o ? w_head.mtval : '0;

  // Commit state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= CQ_RUN;
    else       r_state <= w_nxt;
  end

  cq_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .clr_i       (w_clr),
    .head_o      (w_head),
    .ent_o       (w_ent),
    .count_o     (w_cnt)
  );

endmodule

// File: tb/tb_alupl_commit_queue.sv
// Directed bench for the ALU commit queue.
// Inputs change on negedge; outputs checked 1ns later.
module tb_alupl_commit_queue;
  import super_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           vld;
  pl_out_t        din;
  logic           rdy;
  waw_act_t       waw;
  logic           wreq;
  logic           gnt;
  logic           we;
  logic [4:0]     waddr;
  logic [OpW-1:0] wdata;
  logic           clr;
  logic           ret;
  logic [31:0]    rpc;
  logic           exc;
  logic [31:0]    epc;
  logic [5:0]     emc;
  logic [31:0]    etv;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alupl_commit_queue #(
    .Depth     (2),
    .CHERIoTEn (1'b1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .alupl_valid_i  (vld),
    .alupl_output_i (din),
    .alupl_ds_rdy_o (rdy),
    .waw_act_i      (waw),
    .rf_wreq_o      (wreq),
    .rf_wgnt_i      (gnt),
    .rf_we_o        (we),
    .rf_waddr_o     (waddr),
    .rf_wdata_o     (wdata),
    .rf_wrsv_clr_o  (clr),
    .retire_valid_o (ret),
    .retire_pc_o    (rpc),
    .exc_valid_o    (exc),
    .exc_pc_o       (epc),
    .exc_mcause_o   (emc),
    .exc_mtval_o    (etv)
  );

  task automatic chk(
    input string       tag,
    input logic [95:0] obs,
    input logic [95:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  function automatic pl_out_t mk(
    input logic           w,
    input logic           rs,
    input logic [4:0]     a,
    input logic [OpW-1:0] d,
    input logic           e,
    input logic [31:0]    pc,
    input logic [5:0]     mc
  );
    pl_out_t p;
    p        = '0;
    p.we     = w;
    p.wrsv   = rs;
    p.waddr  = a;
    p.wdata  = d;
    p.err    = e;
    p.pc     = pc;
    p.mcause = mc;
    p.mtval  = 32'hBAD0_0000 | pc;
    return p;
  endfunction

  task automatic waw_set(
    input logic [1:0] v,
    input logic [4:0] r0,
    input logic [4:0] r1
  );
    waw.valid = v;
    waw.rd0   = r0;
    waw.rd1   = r1;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    vld   = 1'b0;
    gnt   = 1'b0;
    din   = '0;
    waw   = '0;

    // reset state
    @(negedge clk); #1;
    chk("rst_rdy", rdy, 0);
    chk("rst_wreq", wreq, 0);
    chk("rst_ret", ret, 0);
    chk("rst_exc", exc, 0);
    chk("rst_waddr", waddr, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_rdy", rdy, 1);
    chk("post_rst_wreq", wreq, 0);

    // single write, granted
    @(negedge clk);
    vld = 1'b1; gnt = 1'b1;
    din = mk(1, 1, 5, 'h1234, 0, 'h10, 0);
    #1;
    chk("t1_rdy", rdy, 1);
    chk("t1_lat", wreq, 0);
    @(negedge clk); vld = 1'b0; #1;
    chk("t1_we", we, 1);
    chk("t1_waddr", waddr, 5);
    chk("t1_wdata", wdata, 'h1234);
    chk("t1_clr", clr, 1);
    chk("t1_ret", ret, 1);
    chk("t1_rpc", rpc, 'h10);
    @(negedge clk); gnt = 1'b0; #1;
    chk("t1_empty", wreq, 0);
    chk("t1_noret", ret, 0);

    // fill to full, then drain in order
    @(negedge clk);
    vld = 1'b1; din = mk(1, 1, 1, 'h11, 0, 'h20, 0);
    #1; chk("t2_rdy0", rdy, 1);
    @(negedge clk);
    din = mk(1, 1, 2, 'h22, 0, 'h24, 0);
    #1;
    chk("t2_rdy1", rdy, 1);
    chk("t2_wreq", wreq, 1);
    chk("t2_nowe", we, 0);
    @(negedge clk);
    din = mk(1, 1, 3, 'h33, 0, 'h28, 0);
    #1; chk("t2_full", rdy, 0);
    @(negedge clk); gnt = 1'b1; #1;
    chk("t2_full2", rdy, 0);
    chk("t2_we_a", we, 1);
    chk("t2_wa_a", waddr, 1);
    @(negedge clk); #1;
    chk("t2_rdy_back", rdy, 1);
    chk("t2_wa_b", waddr, 2);
    @(negedge clk); vld = 1'b0; #1;
    chk("t2_we_c", we, 1);
    chk("t2_wa_c", waddr, 3);
    chk("t2_wd_c", wdata, 'h33);
    @(negedge clk); #1;
    chk("t2_drained", wreq, 0);
    gnt = 1'b0;

    // WAW on a queued entry
    @(negedge clk);
    vld = 1'b1;
    din = mk(1, 1, 7, {1'b1, 64'h55}, 0, 'h30, 0);
    #1;
    @(negedge clk);
    vld = 1'b0; waw_set(2'b10, 0, 7);
    #1;
    chk("t3_wreq", wreq, 1);
    chk("t3_wait", we, 0);
    @(negedge clk);
    waw = '0; gnt = 1'b1;
    #1;
    chk("t3_we", we, 1);
    chk("t3_wa", waddr, 7);
    chk("t3_wd", wdata, {1'b1, 64'h55});
    chk("t3_clr", clr, 0);

    // WAW on the head in the grant cycle
    @(negedge clk);
    gnt = 1'b0; vld = 1'b1;
    din = mk(1, 1, 9, 'h99, 0, 'h34, 0);
    #1;
    @(negedge clk);
    vld = 1'b0; gnt = 1'b1; waw_set(2'b01, 9, 0);
    #1;
    chk("t3h_we", we, 1);
    chk("t3h_clr", clr, 0);

    // WAW on the entry being pushed
    @(negedge clk);
    gnt = 1'b0; vld = 1'b1;
    din = mk(1, 1, 11, 'hB, 0, 'h38, 0);
    waw_set(2'b01, 11, 0);
    #1;
    @(negedge clk);
    vld = 1'b0; waw = '0; gnt = 1'b1;
    #1;
    chk("t3p_wa", waddr, 11);
    chk("t3p_clr", clr, 0);

    // non-matching WAW leaves the release intact
    @(negedge clk);
    vld = 1'b1;
    din = mk(1, 1, 12, 'hC, 0, 'h3C, 0);
    waw_set(2'b11, 13, 14);
    #1;
    @(negedge clk); vld = 1'b0; #1;
    chk("t3n_we", we, 1);
    chk("t3n_clr", clr, 1);
    @(negedge clk); waw = '0; gnt = 1'b0;

    // error entry holds until flush
    vld = 1'b1; gnt = 1'b1;
    din = mk(1, 1, 4, 'h44, 1, 'h80, 2);
    #1;
    @(negedge clk); vld = 1'b0; #1;
    chk("t4_nowreq", wreq, 0);
    chk("t4_nowe", we, 0);
    chk("t4_noret", ret, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("t4_exc", exc, 1);
      chk("t4_epc", epc, 'h80);
      chk("t4_emc", emc, 2);
      chk("t4_etv", etv, 'hBAD0_0080);
      chk("t4_rdy", rdy, 0);
      chk("t4_we", we, 0);
    end
    @(negedge clk); flush = 1'b1; #1;
    chk("t4_fl_exc", exc, 0);
    chk("t4_fl_we", we, 0);
    @(negedge clk); flush = 1'b0; #1;
    chk("t4_rdy", rdy, 1);
    chk("t4_exc_off", exc, 0);
    chk("t4_empty", wreq, 0);
    chk("t4_epc0", epc, 0);

    // flush beats a pending write and a push
    gnt = 1'b0;
    @(negedge clk);
    vld = 1'b1;
    din = mk(1, 1, 12, 'hD, 0, 'h40, 0);
    #1;
    @(negedge clk);
    din = mk(1, 1, 13, 'hE, 0, 'h44, 0);
    #1;
    @(negedge clk); vld = 1'b0; #1;
    chk("t5_full", rdy, 0);
    chk("t5_wreq", wreq, 1);
    @(negedge clk);
    flush = 1'b1; vld = 1'b1; gnt = 1'b1;
    din = mk(1, 1, 14, 'hF, 0, 'h48, 0);
    #1;
    chk("t5_fl_wreq", wreq, 0);
    chk("t5_fl_we", we, 0);
    chk("t5_fl_ret", ret, 0);
    @(negedge clk);
    flush = 1'b0; vld = 1'b0;
    #1;
    chk("t5_wreq0", wreq, 0);
    chk("t5_we0", we, 0);
    chk("t5_rdy", rdy, 1);

    // retire without RF write
    @(negedge clk);
    gnt = 1'b0; vld = 1'b1;
    din = mk(0, 1, 6, 'h6, 0, 'h200, 0);
    #1;
    @(negedge clk);
    din = mk(1, 1, 0, 'h7, 0, 'h204, 0);
    #1;
    chk("t6_ret_a", ret, 1);
    chk("t6_pc_a", rpc, 'h200);
    chk("t6_wreq_a", wreq, 0);
    chk("t6_we_a", we, 0);
    @(negedge clk); vld = 1'b0; #1;
    chk("t6_ret_b", ret, 1);
    chk("t6_pc_b", rpc, 'h204);
    chk("t6_wreq_b", wreq, 0);
    chk("t6_we_b", we, 0);
    chk("t6_clr_b", clr, 0);
    @(negedge clk); #1;
    chk("t6_idle", ret, 0);

    // asynchronous reset drops pending entries
    @(negedge clk);
    vld = 1'b1;
    din = mk(1, 1, 15, 'h15, 0, 'h50, 0);
    #1;
    @(negedge clk); vld = 1'b0; #1;
    chk("t7_wreq", wreq, 1);
    #1 rst = 1'b1;
    #1;
    chk("t7_rst_wreq", wreq, 0);
    chk("t7_rst_rdy", rdy, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("t7_empty", wreq, 0);
    chk("t7_rdy", rdy, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
